// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit pipeline memory stage: FSM encodings,
// default responder geometry and the request record latched on acceptance.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_LAT    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    import cpu_pkg::*;

    logic              en;
    logic              wr;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              stall;
    logic              done;

    modport master (output en, wr, addr, wdata, input rdata, stall, done);
    modport slave  (input en, wr, addr, wdata, output rdata, stall, done);

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word array; no reset so it can map onto RAM.
module dmem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls the
// pipeline for LAT cycles, then commits/reads and pulses done.
//
//   state   | meaning
//   ST_IDLE | no request outstanding, accept on en
//   ST_WAIT | latency countdown, pipeline stalled
//   ST_DONE | access committed, done strobe, en ignored
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LAT    = DEF_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              rd_vld_q, rd_vld_d;
    logic              go_done;
    logic              arr_we, arr_re;
    logic [DATA_W-1:0] arr_rdata;
    logic              addr_unused;

    assign addr_unused = ^{bus.addr[0], bus.addr[15:ADDR_W+1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        go_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    req_d.wr    = bus.wr;
                    req_d.wdata = bus.wdata;
                    idx_d       = bus.addr[ADDR_W:1];
                    cnt_d       = LAT_M1;
                    if (LAT == 1) begin
                        state_d = ST_DONE;
                        go_done = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    go_done = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The _d request values are the live inputs on a LAT=1 accept and the
    // latched ones otherwise, so the array sees the right request either way.
    // Gating with rst_n keeps a reset-time accept from touching the array.
    assign arr_we   = go_done &  req_d.wr & rst_n;
    assign arr_re   = go_done & ~req_d.wr & rst_n;
    assign rd_vld_d = rd_vld_q | arr_re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            req_q    <= '0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            idx_q    <= idx_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (idx_d),
        .wdata (req_d.wdata),
        .rdata (arr_rdata)
    );

    // The array output register has no reset; rd_vld_q presents 0 until a
    // read has completed since the last reset.
    assign bus.rdata = rd_vld_q ? arr_rdata : '0;
    assign bus.stall = rst_n & (((state_q == ST_IDLE) & bus.en) | (state_q == ST_WAIT));
    assign bus.done  = (state_q == ST_DONE);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the 16-bit pipeline. It receives the memory-stage request formed from the decoded `DMEM_en`/`MemWrite`/`MemRead` controls and serves it after a fixed, parameterised latency. While a request is outstanding it drives a stall back to the pipeline. It returns read data with a one-cycle completion strobe.

## Interface
- `ADDR_W`, 10: word-address width; storage depth is 2^ADDR_W 16-bit words.
- `LAT`, 4: access latency in cycles, legal range 1..15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  request present (driven from DMEM_en).
- `wr`  in  1  1 = write, 0 = read (driven from MemWrite); sampled only with `en`.
- `addr`  in  16  byte address; word index = `addr[ADDR_W:1]`; `addr[0]` and bits above ADDR_W are ignored.
- `wdata`  in  16  store data; sampled only with `en`.
- `rdata`  out  16  read data; registered, held until the next read completes.
- `stall`  out  1  pipeline hold request.
- `done`  out  1  one-cycle completion strobe.

## Operation
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if `en`=1, latch `wr`/word index/`wdata`, load counter with LAT-1, go to WAIT (or DONE directly when LAT=1); otherwise stay in IDLE.
  - WAIT: decrement counter each cycle; when the counter reaches 1, go to DONE.
  - DONE: always return to IDLE; `en` is ignored in DONE, because it is the same held request completing.
- `stall` = (IDLE and `en`) or WAIT. This path is combinational from `en` so the requesting instruction is held in the same cycle. `stall`=0 in DONE.
- `done`=1 only in DONE.
- Write commit: array word written on the edge entering DONE. `rdata` is unchanged by writes.
- Read: `rdata` is loaded from the array on the edge entering DONE.
- Same-address write followed by a read returns the new data.
- Word index wraps modulo 2^ADDR_W; no error is flagged.
- Array contents are not reset; they are undefined at power-up.

## Timing
- Reset values: state=IDLE, counter=0, `rdata`=16'h0000, `done`=0, `stall`=0 (with `en`=0).
- Request accepted at edge E0. `done`=1 during cycle LAT after E0; `stall` is high from the request cycle through cycle LAT-1.
- Total pipeline hold for one access is LAT cycles. With LAT=1, `done` is in the cycle immediately after acceptance.
- Back-to-back requests: minimum issue interval is LAT+1 cycles. A new `en` is accepted no earlier than the cycle after DONE.
- Reset asserted mid-operation: FSM aborts to IDLE immediately and `stall`/`done` drop asynchronously. A pending write is NOT committed, and `rdata` clears to 0.
- Changes on `wr`/`addr`/`wdata` after acceptance have no effect.

## Structure
- Shared package/header `cpu_pkg`:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
  - Default LAT and ADDR_W.
  - Data width constant 16.
- Sub-module `dmem_array`: single-port synchronous array (clk, we, re, idx, wdata, rdata) with no reset, so synthesis can map it to RAM.
- FSM, counter and request latch live in `dmem_responder`.

## Test plan
- LAT=4: write 16'hBEEF to addr 16'h0010, then read addr 16'h0010.
  - Each access: `stall`=1 for 4 cycles, then `done` pulses once.
  - Read `rdata`=16'hBEEF.
- LAT=1: write 16'h1234 to addr 0x0002, then read addr 0x0003.
  - `addr[0]` is ignored, so `rdata`=16'h1234.
  - Each access shows a 1-cycle stall and a 1-cycle done.
- Wrap: ADDR_W=10, write 16'h00AA to addr 16'h0800, then read addr 16'h0000 → `rdata`=16'h00AA.
- Reset mid-op:
  - Write 16'h5555 to addr 0x0020, which holds 16'h1111.
  - Assert `rst_n`=0 in the second WAIT cycle.
  - Required: `stall`/`done` go low at once and `rdata`=0.
  - A subsequent read of 0x0020 returns 16'h1111.
- `en` held high across DONE: exactly one `done` pulse, and a second access starts the following cycle (stall high again). `en` low throughout: `stall`=`done`=0 and `rdata` unchanged.
